// File: rtl/fifo_burst_rd.sv
// fifo_burst_rd: reads fixed-length bursts of 16-bit words from a
// non-show-ahead FIFO and hands them to a valid/ready downstream port through
// a small output buffer. Reads are throttled so the buffer can never overflow.
// Optional feature macro: FIFO_BURST_RD_CHECKSUM_EN (per-burst modulo-2^16 sum).
module fifo_burst_rd #(
    parameter int BURST_LEN  = 64,
    parameter int OBUF_DEPTH = 4
) (
    input  logic        rd_clk,
    input  logic        rd_rst,
    input  logic        rd_empty,
    input  logic [8:0]  rd_usedw,
    input  logic [15:0] rd_data,
    output logic        rd_req,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        burst_busy,
    output logic        burst_done,
    output logic [15:0] burst_cnt,
    output logic [15:0] burst_sum
);

    localparam int PW = $clog2(OBUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [8:0]  LEN_C    = 9'(BURST_LEN);
    localparam logic [8:0]  LEN_M1_C = 9'(BURST_LEN - 1);
    localparam logic [CW:0] DEPTH_C  = (CW + 1)'(OBUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_r;
    logic [8:0]      rd_cnt_r;      // reads issued in the current burst
    logic [8:0]      out_cnt_r;     // words handed downstream in the current burst
    logic            inflight_r;    // a read was issued last cycle; its word is on rd_data now
    logic            busy_r;
    logic [15:0]     burst_cnt_r;

    logic [15:0]     obuf_mem_r [OBUF_DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   obuf_cnt_r;

    logic            rd_req_s;
    logic            out_valid_s;
    logic [15:0]     out_data_s;
    logic            xfer_s;
    logic            last_xfer_s;
    logic [CW:0]     committed_s;

    // Decide whether a FIFO read may be issued this cycle: only inside a burst,
    // only when the FIFO has data, and only if every word already owed to the
    // buffer (stored plus in flight) still leaves room for one more.
    always_comb begin
        rd_req_s    = 1'b0;
        committed_s = {1'b0, obuf_cnt_r} + {{CW{1'b0}}, inflight_r};
        if ((state_r == BURST) && !rd_empty && (committed_s < DEPTH_C) && (rd_cnt_r < LEN_C)) begin
            rd_req_s = 1'b1;
        end else begin
            rd_req_s = 1'b0;
        end
    end

    // Downstream handshake decode and end-of-burst detection.
    always_comb begin
        out_valid_s = (obuf_cnt_r != {CW{1'b0}});
        out_data_s  = 16'h0000;
        if (out_valid_s) begin
            out_data_s = obuf_mem_r[rd_ptr_r];
        end else begin
            out_data_s = 16'h0000;
        end
        xfer_s      = out_valid_s && out_ready;
        last_xfer_s = (state_r == DRAIN) && xfer_s && (out_cnt_r == LEN_M1_C);
    end

    // Burst sequencer: read/transfer counters, busy flag and completed-burst count.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_r     <= IDLE;
            rd_cnt_r    <= 9'd0;
            out_cnt_r   <= 9'd0;
            inflight_r  <= 1'b0;
            busy_r      <= 1'b0;
            burst_cnt_r <= 16'h0000;
        end else begin
            inflight_r <= rd_req_s;
            case (state_r)
                IDLE: begin
                    if (rd_usedw >= LEN_C) begin
                        state_r   <= BURST;
                        busy_r    <= 1'b1;
                        rd_cnt_r  <= 9'd0;
                        out_cnt_r <= 9'd0;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                BURST: begin
                    if (rd_req_s) begin
                        rd_cnt_r <= rd_cnt_r + 9'd1;
                    end else begin
                        rd_cnt_r <= rd_cnt_r;
                    end
                    if (xfer_s) begin
                        out_cnt_r <= out_cnt_r + 9'd1;
                    end else begin
                        out_cnt_r <= out_cnt_r;
                    end
                    // The final read moves us on immediately so rd_req drops as
                    // the count reaches the burst length.
                    if (rd_req_s && (rd_cnt_r == LEN_M1_C)) begin
                        state_r <= DRAIN;
                    end else begin
                        state_r <= BURST;
                    end
                end
                DRAIN: begin
                    if (xfer_s) begin
                        out_cnt_r <= out_cnt_r + 9'd1;
                    end else begin
                        out_cnt_r <= out_cnt_r;
                    end
                    if (last_xfer_s) begin
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        burst_cnt_r <= burst_cnt_r + 16'h0001;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output buffer bookkeeping: pointers and occupancy. The in-flight flag is
    // cleared by reset, so a word landing right after reset release is dropped.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            obuf_cnt_r <= {CW{1'b0}};
        end else begin
            if (inflight_r) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (xfer_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({inflight_r, xfer_s})
                2'b10:   obuf_cnt_r <= obuf_cnt_r + CW'(1);
                2'b01:   obuf_cnt_r <= obuf_cnt_r - CW'(1);
                default: obuf_cnt_r <= obuf_cnt_r;
            endcase
        end
    end

    // Output buffer storage: capture the word returned for last cycle's read.
    always_ff @(posedge rd_clk) begin
        if (inflight_r) begin
            obuf_mem_r[wr_ptr_r] <= rd_data;
        end else begin
            obuf_mem_r[wr_ptr_r] <= obuf_mem_r[wr_ptr_r];
        end
    end

`ifdef FIFO_BURST_RD_CHECKSUM_EN
    logic [15:0] acc_r;
    logic [15:0] sum_r;

    // Per-burst checksum: accumulate transferred words, publish on the last one.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            acc_r <= 16'h0000;
            sum_r <= 16'h0000;
        end else if (last_xfer_s) begin
            sum_r <= acc_r + out_data_s;
            acc_r <= 16'h0000;
        end else if (xfer_s) begin
            acc_r <= acc_r + out_data_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign burst_sum = sum_r;
`else
    assign burst_sum = 16'h0000;
`endif

    assign rd_req     = rd_req_s;
    assign out_valid  = out_valid_s;
    assign out_data   = out_data_s;
    assign burst_busy = busy_r;
    assign burst_done = last_xfer_s;
    assign burst_cnt  = burst_cnt_r;

endmodule

// File: tb/tb_fifo_burst_rd.sv
// Testbench for fifo_burst_rd: a FIFO model feeds the DUT; every word pushed
// into the FIFO is also pushed onto an expected-output queue that is popped
// and compared whenever the DUT transfers a word downstream.
module tb_fifo_burst_rd;

    logic        rd_clk = 1'b0;
    logic        rd_rst;
    logic        rd_empty;
    logic [8:0]  rd_usedw;
    logic [15:0] rd_data;
    logic        rd_req;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        burst_busy;
    logic        burst_done;
    logic [15:0] burst_cnt;
    logic [15:0] burst_sum;

    fifo_burst_rd #(.BURST_LEN(64), .OBUF_DEPTH(4)) dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_empty(rd_empty), .rd_usedw(rd_usedw),
        .rd_data(rd_data), .rd_req(rd_req), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .burst_busy(burst_busy), .burst_done(burst_done),
        .burst_cnt(burst_cnt), .burst_sum(burst_sum)
    );

    always #5 rd_clk = ~rd_clk;

    logic [15:0] fifo_q[$];
    logic [15:0] exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [15:0] exp_cnt = 16'h0000;
    logic [15:0] run_sum = 16'h0000;
    int          req_in_burst = 0;
    int          xfer_in_burst = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0000;
    logic        force_empty = 1'b0;
    logic        ready_nxt = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic update_flags();
        rd_usedw = 9'(fifo_q.size());
        rd_empty = (fifo_q.size() == 0) || force_empty;
    endtask

    task automatic push_words(input logic [15:0] base, input int n, input bit rnd);
        logic [15:0] w;
        for (int i = 0; i < n; i++) begin
            w = rnd ? 16'($urandom) : base + 16'(i);
            fifo_q.push_back(w);
            exp_q.push_back(w);
        end
        update_flags();
    endtask

    // One clock cycle: entered at a falling edge, returns at the next one.
    task automatic cycle(output bit got_done);
        bit          pop;
        logic [15:0] w;
        pop = 1'b0;
        got_done = 1'b0;
        #1;
        if (rd_req === 1'b1) begin
            req_in_burst++;
            chk("no_underflow_read", {31'd0, rd_empty}, 32'd0);
            pop = 1'b1;
        end
        if (prev_stall) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", {16'd0, out_data}, {16'd0, prev_data});
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            xfer_in_burst++;
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {16'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                chk("out_data", {16'd0, out_data}, {16'd0, w});
                run_sum = run_sum + w;
            end
        end
        if (burst_done === 1'b1) begin
            got_done = 1'b1;
            chk("done_word_count", xfer_in_burst, 32'd64);
            chk("done_read_count", req_in_burst, 32'd64);
        end
        prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
        prev_data  = out_data;
        @(posedge rd_clk);
        #1;
        if (pop && fifo_q.size() != 0) rd_data = fifo_q.pop_front();
        else rd_data = 16'hBAD0;
        out_ready = ready_nxt;
        update_flags();
        if (got_done) begin
            exp_cnt = exp_cnt + 16'h0001;
            chk("burst_cnt", {16'd0, burst_cnt}, {16'd0, exp_cnt});
`ifdef FIFO_BURST_RD_CHECKSUM_EN
            chk("burst_sum", {16'd0, burst_sum}, {16'd0, run_sum});
`else
            chk("burst_sum_off", {16'd0, burst_sum}, 32'd0);
`endif
            chk("busy_after_done", {31'd0, burst_busy}, 32'd0);
            run_sum = 16'h0000;
            xfer_in_burst = 0;
            req_in_burst = 0;
        end
        @(negedge rd_clk);
    endtask

    // mode 0: ready high; mode 1: ready toggling then held low 10 cycles;
    // mode 2: ready high, FIFO looks empty for 5 cycles after read 20.
    // stop_at > 0 returns once that many words have transferred.
    task automatic run_burst(input int mode, input int stop_at);
        int c;
        int fe;
        bit got;
        c = 0; fe = 0; got = 1'b0;
        while (!got && c < 1000 && !(stop_at > 0 && xfer_in_burst >= stop_at)) begin
            case (mode)
                1: ready_nxt = (c < 30) ? c[0] : ((c < 40) ? 1'b0 : 1'b1);
                default: ready_nxt = 1'b1;
            endcase
            if (mode == 2 && req_in_burst >= 20 && fe < 5) begin
                force_empty = 1'b1;
                fe++;
            end else begin
                force_empty = 1'b0;
            end
            cycle(got);
            c++;
        end
        force_empty = 1'b0;
        if (stop_at == 0) chk("burst_completed", {31'd0, got}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_req"}, {31'd0, rd_req}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
        chk({tag, "_busy"}, {31'd0, burst_busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, burst_done}, 32'd0);
        chk({tag, "_cnt"}, {16'd0, burst_cnt}, 32'd0);
        chk({tag, "_sum"}, {16'd0, burst_sum}, 32'd0);
    endtask

    initial begin
        bit g;
        rd_rst = 1'b1; rd_empty = 1'b1; rd_usedw = 9'd0; rd_data = 16'h0000; out_ready = 1'b0;
        repeat (2) @(posedge rd_clk);
        @(negedge rd_clk);
        check_reset_outputs("reset");
        @(posedge rd_clk); #1;
        rd_rst = 1'b0;
        @(negedge rd_clk);

        // 63 words available: below threshold, nothing may start.
        push_words(16'h0000, 63, 1'b0);
        ready_nxt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle(g);
            chk("short_no_req", {31'd0, rd_req}, 32'd0);
            chk("short_no_busy", {31'd0, burst_busy}, 32'd0);
        end

        // 64th word arrives: burst of 0x0000..0x003F.
        push_words(16'h003F, 1, 1'b0);
        run_burst(0, 0);
        chk("first_burst_cnt", {16'd0, burst_cnt}, 32'd1);
`ifdef FIFO_BURST_RD_CHECKSUM_EN
        chk("first_burst_sum", {16'd0, burst_sum}, 32'h07E0);
`endif

        // Backpressure burst with random data.
        push_words(16'h0000, 64, 1'b1);
        run_burst(1, 0);

        // FIFO empty pause mid-burst.
        push_words(16'h1000, 64, 1'b0);
        run_burst(2, 0);

        // Reset after 30 words.
        push_words(16'h2000, 64, 1'b0);
        run_burst(0, 30);
        rd_rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        fifo_q.delete(); exp_q.delete();
        exp_cnt = 16'h0000; run_sum = 16'h0000;
        req_in_burst = 0; xfer_in_burst = 0; prev_stall = 1'b0;
        rd_data = 16'hDEAD;
        update_flags();
        @(posedge rd_clk); #1;
        rd_rst = 1'b0;
        @(negedge rd_clk);
        push_words(16'h3000, 64, 1'b0);
        run_burst(0, 0);
        chk("after_reset_cnt", {16'd0, burst_cnt}, 32'd1);

        // Counter wrap: preset the completed-burst count to 0xFFFF.
        force dut.burst_cnt_r = 16'hFFFF;
        @(posedge rd_clk); #1;
        release dut.burst_cnt_r;
        exp_cnt = 16'hFFFF;
        @(negedge rd_clk);
        chk("preset_cnt", {16'd0, burst_cnt}, 32'h0000FFFF);
        push_words(16'h4000, 64, 1'b1);
        run_burst(0, 0);
        chk("wrap_cnt", {16'd0, burst_cnt}, 32'd0);
        chk("leftover_words", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
